// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/compare ops, bit-serial shifts
// and shift-add multiply, with valid/ready handshakes on both sides.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             overflow,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, nxt;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] sum, dif, fin_res;
  logic             fin_ovf, fin_err;
  logic             accept, last;

  assign accept = in_valid & in_ready;
  assign last   = (state == BUSY) && (cnt == '0);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next state
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  nxt = BUSY;
      BUSY:    if (cnt == '0) nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // handshake outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  assign sum = a_q + b_q;
  assign dif = a_q - b_q;

  always_comb begin
    fin_res = '0;
    fin_ovf = 1'b0;
    fin_err = 1'b0;
    case (op_q)
      OP_AND:  fin_res = a_q & b_q;
      OP_OR:   fin_res = a_q | b_q;
      OP_ADD: begin
        fin_res = sum;
        fin_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                  (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_XOR:  fin_res = a_q ^ b_q;
      OP_NOR:  fin_res = ~(a_q | b_q);
      OP_SUB: begin
        fin_res = dif;
        fin_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                  (dif[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLTU: fin_res = {{(WIDTH-1){1'b0}}, a_q < b_q};
      OP_SLT:  fin_res = {{(WIDTH-1){1'b0}},
                          $signed(a_q) < $signed(b_q)};
      OP_SRL, OP_SLL, OP_SRA: fin_res = a_q;
      OP_MUL:  fin_res = acc;
      default: fin_err = 1'b1;
    endcase
  end

  // operand latch and one iteration step per BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else if (accept) begin
      op_q <= op;
      a_q  <= A;
      b_q  <= B;
      acc  <= '0;
      case (op)
        OP_SRL, OP_SLL, OP_SRA:
          cnt <= {1'b0, B[SHW-1:0]};
        OP_MUL:  cnt <= CW'(WIDTH);
        default: cnt <= '0;
      endcase
    end else if (state == BUSY && cnt != '0) begin
      cnt <= cnt - 1'b1;
      case (op_q)
        OP_SRL: a_q <= a_q >> 1;
        OP_SLL: a_q <= a_q << 1;
        OP_SRA: a_q <= WIDTH'($signed(a_q) >>> 1);
        OP_MUL: begin
          if (b_q[0]) acc <= acc + a_q;
          a_q <= a_q << 1;
          b_q <= b_q >> 1;
        end
        default: ;
      endcase
    end
  end

  // result and flags are registered together and held through DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      res      <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
    end else if (last) begin
      res      <= fin_res;
      zero     <= (fin_res == '0);
      overflow <= fin_ovf;
      err      <= fin_err;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases then randomized ops
// against an arithmetic reference model, with stalls and latency checks.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] A, B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        zero, overflow, err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .zero      (zero),
    .overflow  (overflow),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference: plain arithmetic on the operation's meaning
  task automatic model(input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] r,
                       output logic v, output logic e, output int lat);
    longint sa, sb, s;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    r = 32'd0; v = 1'b0; e = 1'b0; lat = 1;
    case (o)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2: begin
        s = sa + sb; r = a + b;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd3:  r = a ^ b;
      4'd4:  r = ~(a | b);
      4'd5: begin r = a >> sh; lat = 1 + sh; end
      4'd6: begin
        s = sa - sb; r = a - b;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7:  r = (a < b) ? 32'd1 : 32'd0;
      4'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: begin r = a << sh; lat = 1 + sh; end
      4'd10: begin r = 32'($signed(a) >>> sh); lat = 1 + sh; end
      4'd11: begin r = a * b; lat = 33; end
      default: e = 1'b1;
    endcase
  endtask

  task automatic recover();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int stall);
    logic [31:0] er;
    logic ev, ee;
    int elat, lat, t;
    model(o, a, b, er, ev, ee, elat);
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    op = o; A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; op = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", 32'(lat), 32'(elat));
    if (!out_valid) begin
      recover();
      return;
    end
    chk("res", res, er);
    chk("zero", 32'(zero), 32'(er == 32'd0));
    chk("overflow", 32'(overflow), 32'(ev));
    chk("err", 32'(err), 32'(ee));
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_res", res, er);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("consumed_valid", 32'(out_valid), 32'd0);
    chk("consumed_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res", res, 32'd0);
    chk("rst_flags", {29'd0, zero, overflow, err}, 32'd0);
    rst = 1'b0;

    do_op(4'd2, 32'h7FFF_FFFF, 32'd1, 0);
    chk("add_ovf_res", res, 32'h8000_0000);
    do_op(4'd6, 32'd5, 32'd5, 0);
    do_op(4'd5, 32'h8000_0000, 32'd31, 1);
    chk("srl_res", res, 32'd1);
    do_op(4'd10, 32'h8000_0000, 32'd31, 0);
    chk("sra_res", res, 32'hFFFF_FFFF);
    do_op(4'd9, 32'd1, 32'd0, 0);
    do_op(4'd11, 32'hFFFF_FFFF, 32'd3, 5);
    chk("mul_res", res, 32'hFFFF_FFFD);
    do_op(4'd8, 32'hFFFF_FFFF, 32'd1, 0);
    chk("slt_res", res, 32'd1);
    do_op(4'd7, 32'hFFFF_FFFF, 32'd1, 0);
    chk("sltu_res", res, 32'd0);
    do_op(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 2);
    chk("illegal_err", {err, zero}, 32'd3);

    op = 4'd11; A = 32'hDEAD_BEEF; B = 32'h1234_5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    do_op(4'd0, 32'h0000_00F0, 32'h0000_003C, 0);
    chk("and_res", res, 32'h0000_0030);

    for (int n = 0; n < 2000; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: ra = 32'h7FFF_FFFF;
        1: rb = rb & 32'h8000_001F;
        default: ;
      endcase
      do_op(4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
